root_host_input_unit: RTL and testbench
=======================================

Name: root_host_input_unit

Overview:
- Primary-input stage of the accelerator root node. Sits directly upstream of the root output unit.
- Accepts host write and read commands over a valid/ready handshake and buffers them in a command FIFO.
- Expands each command into one or more router flits, issued to the root output unit's tx port under its credit gate.
- Limits in-flight reads so the root read-return FIFO can never overflow.

Parameters:
- CMD_FIFO_DEPTH, 8, command FIFO entries (power of 2).
- MAX_RD_OUTSTANDING, 16, maximum in-flight read flits; equals TOT_FIFO_DEPTH.
- LEN_WIDTH, 8, width of the burst length field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- host_req_vld  in  1  host command valid.
- host_req_rdy  out  1  host command ready; equals ~cmd_fifo_full.
- host_req_op  in  1  0 = write, 1 = read.
- host_req_addr  in  16  start address.
- host_req_data  in  16  write data. The same value is written to every beat of a burst.
- host_req_len  in  LEN_WIDTH  beats minus 1.
- router_rdy  in  1  downstream credit available; from the root output unit.
- tx_block  in  1  rank controller owns the tx port this cycle.
- tx_en  out  1  flit issue strobe.
- tx_data  out  36  flit: info[35:32], addr[31:16], data[15:0].
- rd_resp  in  1  one read flit drained to the host; from read_data_vld.
- busy  out  1  unit still holds work.
- err_underflow  out  1  sticky flag: rd_resp arrived while the outstanding count was 0.

Behaviour:
- Reset is synchronous. On reset:
  - FIFO pointers cleared; FSM goes to IDLE.
  - Beat counter and rd_outstanding cleared; err_underflow cleared.
  - tx_en=0 and tx_data=0 in the reset cycle.
  - A burst in progress is dropped, with no partial completion.
- Host accept:
  - A command is pushed when host_req_vld & host_req_rdy.
  - FIFO entry is {op, len, addr, data}.
  - host_req_rdy is low when the FIFO holds CMD_FIFO_DEPTH entries.
  - Push and pop in the same cycle on a full FIFO is not allowed, because rdy is already low.
- FSM states:
  - IDLE: if the FIFO is not empty, pop into cur_op/cur_len/cur_addr/cur_data, clear beat, and go to ISSUE next cycle. No tx in IDLE.
  - ISSUE: define can_send = router_rdy & ~tx_block & (cur_op==write | rd_outstanding < MAX_RD_OUTSTANDING).
    - When can_send: tx_en=1 combinationally in that cycle, and beat increments.
    - When beat==cur_len on a send: return to IDLE. This gives a one-cycle bubble between commands.
    - When can_send=0: hold all state; tx_en=0; tx_data=0.
- tx_data fields:
  - info is ROUTER_INFO_WRITE (4'h1) for writes and ROUTER_INFO_READ_REQ (4'h2) for reads.
  - addr = cur_addr + beat, 16-bit modulo; 16'hFFFF wraps to 16'h0000.
  - data = cur_data for writes, 16'h0000 for reads.
- Latency: the first flit appears at the earliest 2 cycles after the push cycle (push, IDLE pop, ISSUE send).
- rd_outstanding:
  - +1 on tx_en with a read.
  - -1 on rd_resp.
  - Both in the same cycle: unchanged.
  - rd_resp at 0: count stays 0 and err_underflow is set.
- busy = ~fifo_empty | (state==ISSUE) | (rd_outstanding!=0).

Decomposition:
- Shared header router.vh: ROUTER_WIDTH, ROUTER_INFO_WIDTH/ADDR/DATA widths, ROUTER_INFO_WRITE, ROUTER_INFO_READ_REQ, ROUTER_INFO_READ (return), TOT_FIFO_DEPTH.
- Reuse the existing fifo_sync for the command FIFO. Its width is 1+LEN_WIDTH+32 and its depth is CMD_FIFO_DEPTH.
- No new sub-module.

Test Plan:
- Write, len=0, addr 0x0010, data 0xBEEF, router_rdy=1:
  - push at cycle 0 → tx_en at cycle 2, tx_data=0x1_0010_BEEF.
  - busy low at cycle 3.
- Read burst, len=3, addr 0xFFFE:
  - four flits with addr FFFE, FFFF, 0000, 0001.
  - info=2, data=0.
  - rd_outstanding=4.
- Read burst, len=19, no rd_resp:
  - exactly 16 flits issued, then stall.
  - one rd_resp pulse → exactly one more flit.
  - rd_resp and tx_en together leave the count unchanged.
- Flow control mid-burst:
  - router_rdy=0 for 3 cycles at beat 2, then tx_block=1 for 1 cycle → no tx_en during either window.
  - beat and addr resume without skip or repeat.
- FIFO full: 9 pushes with router_rdy=0 → host_req_rdy low after the 8th entry is held.
- Reset mid-burst: rst during beat 1 of a len=5 write → next cycle tx_en=0, busy=0, host_req_rdy=1. A rd_resp afterwards sets err_underflow.

Source files
------------

// File: rtl/root_host_input_unit_pkg.sv
// Shared router flit definitions and local types for the root host input unit.
package root_host_input_unit_pkg;

    localparam int ROUTER_INFO_WIDTH = 4;
    localparam int ROUTER_ADDR_WIDTH = 16;
    localparam int ROUTER_DATA_WIDTH = 16;
    localparam int ROUTER_WIDTH      = ROUTER_INFO_WIDTH + ROUTER_ADDR_WIDTH + ROUTER_DATA_WIDTH;

    localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_WRITE    = 4'h1;
    localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_READ_REQ = 4'h2;
    localparam logic [ROUTER_INFO_WIDTH-1:0] ROUTER_INFO_READ     = 4'h3;

    // Depth of the root read-return FIFO; bounds the number of reads in flight.
    localparam int TOT_FIFO_DEPTH = 16;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } hiu_state_e;

    // Builds one router flit; read requests carry no payload.
    function automatic logic [ROUTER_WIDTH-1:0] make_flit(
        input logic                         op,
        input logic [ROUTER_ADDR_WIDTH-1:0] addr,
        input logic [ROUTER_DATA_WIDTH-1:0] data
    );
        logic [ROUTER_INFO_WIDTH-1:0] info;
        logic [ROUTER_DATA_WIDTH-1:0] payload;
        info    = (op == OP_READ) ? ROUTER_INFO_READ_REQ : ROUTER_INFO_WRITE;
        payload = (op == OP_READ) ? '0 : data;
        return {info, addr, payload};
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO; the head entry is visible on pop_data whenever not empty.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer only on an accepted push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because empty masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/root_host_input_unit.sv
// Root host input unit: buffers host commands and expands them into router flits,
// throttling reads so the root read-return FIFO can never overflow.
module root_host_input_unit
    import root_host_input_unit_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH     = 8,
    parameter int MAX_RD_OUTSTANDING = TOT_FIFO_DEPTH,
    parameter int LEN_WIDTH          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_req_vld,
    output logic                 host_req_rdy,
    input  logic                 host_req_op,
    input  logic [15:0]          host_req_addr,
    input  logic [15:0]          host_req_data,
    input  logic [LEN_WIDTH-1:0] host_req_len,
    input  logic                 router_rdy,
    input  logic                 tx_block,
    output logic                 tx_en,
    output logic [35:0]          tx_data,
    input  logic                 rd_resp,
    output logic                 busy,
    output logic                 err_underflow
);

    localparam int CMD_WIDTH    = 1 + LEN_WIDTH + ROUTER_ADDR_WIDTH + ROUTER_DATA_WIDTH;
    localparam int RD_CNT_WIDTH = $clog2(MAX_RD_OUTSTANDING + 1);
    localparam logic [RD_CNT_WIDTH-1:0] RD_CNT_MAX = RD_CNT_WIDTH'(MAX_RD_OUTSTANDING);

    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [CMD_WIDTH-1:0]         fifo_wr_data;
    logic [CMD_WIDTH-1:0]         fifo_rd_data;

    logic                         head_op;
    logic [LEN_WIDTH-1:0]         head_len;
    logic [ROUTER_ADDR_WIDTH-1:0] head_addr;
    logic [ROUTER_DATA_WIDTH-1:0] head_data;

    hiu_state_e                   state_q, state_d;
    logic                         cur_op_q, cur_op_d;
    logic [LEN_WIDTH-1:0]         cur_len_q, cur_len_d;
    logic [ROUTER_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ROUTER_DATA_WIDTH-1:0] cur_data_q, cur_data_d;
    logic [LEN_WIDTH-1:0]         beat_q, beat_d;
    logic [RD_CNT_WIDTH-1:0]      rd_cnt_q, rd_cnt_d;
    logic                         err_q, err_d;

    logic                         can_send;
    logic                         send_read;
    logic [ROUTER_ADDR_WIDTH-1:0] beat_addr;

    assign host_req_rdy = ~fifo_full;
    assign fifo_push    = host_req_vld & ~fifo_full & ~rst;
    assign fifo_wr_data = {host_req_op, host_req_len, host_req_addr, host_req_data};

    assign head_op   = fifo_rd_data[CMD_WIDTH-1];
    assign head_len  = fifo_rd_data[CMD_WIDTH-2 -: LEN_WIDTH];
    assign head_addr = fifo_rd_data[ROUTER_ADDR_WIDTH+ROUTER_DATA_WIDTH-1 -: ROUTER_ADDR_WIDTH];
    assign head_data = fifo_rd_data[ROUTER_DATA_WIDTH-1:0];

    fifo_sync #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wr_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Beat address wraps modulo 2^16; reads may only go out while the return FIFO has room.
    assign beat_addr = cur_addr_q + ROUTER_ADDR_WIDTH'(beat_q);
    assign can_send  = router_rdy & ~tx_block & ((cur_op_q == OP_WRITE) | (rd_cnt_q < RD_CNT_MAX));

    // Command FSM: IDLE pops the next command, ISSUE emits one flit per granted cycle.
    always_comb begin
        state_d    = state_q;
        cur_op_d   = cur_op_q;
        cur_len_d  = cur_len_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        beat_d     = beat_q;
        fifo_pop   = 1'b0;
        tx_en      = 1'b0;
        tx_data    = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        cur_op_d   = head_op;
                        cur_len_d  = head_len;
                        cur_addr_d = head_addr;
                        cur_data_d = head_data;
                        beat_d     = '0;
                        state_d    = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (can_send) begin
                        tx_en   = 1'b1;
                        tx_data = make_flit(cur_op_q, beat_addr, cur_data_q);
                        beat_d  = beat_q + LEN_WIDTH'(1);
                        if (beat_q == cur_len_q) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outstanding-read tracking; a response with nothing outstanding latches the error flag.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        err_d     = err_q;
        send_read = tx_en & (cur_op_q == OP_READ);
        if (send_read && !rd_resp) begin
            rd_cnt_d = rd_cnt_q + RD_CNT_WIDTH'(1);
        end else if (!send_read && rd_resp) begin
            if (rd_cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                rd_cnt_d = rd_cnt_q - RD_CNT_WIDTH'(1);
            end
        end
    end

    // State registers; reset drops any burst in progress without completing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_op_q   <= OP_WRITE;
            cur_len_q  <= '0;
            cur_addr_q <= '0;
            cur_data_q <= '0;
            beat_q     <= '0;
            rd_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_op_q   <= cur_op_d;
            cur_len_q  <= cur_len_d;
            cur_addr_q <= cur_addr_d;
            cur_data_q <= cur_data_d;
            beat_q     <= beat_d;
            rd_cnt_q   <= rd_cnt_d;
            err_q      <= err_d;
        end
    end

    assign busy          = ~fifo_empty | (state_q == ST_ISSUE) | (rd_cnt_q != '0);
    assign err_underflow = err_q;

endmodule

// File: tb/tb_root_host_input_unit.sv
// Self-checking bench for root_host_input_unit: table of single-beat commands
// followed by hand-written burst, throttling, flow-control, full and reset sequences.
module tb_root_host_input_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req_vld;
    logic        host_req_rdy;
    logic        host_req_op;
    logic [15:0] host_req_addr;
    logic [15:0] host_req_data;
    logic [7:0]  host_req_len;
    logic        router_rdy;
    logic        tx_block;
    logic        tx_en;
    logic [35:0] tx_data;
    logic        rd_resp;
    logic        busy;
    logic        err_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  exp_info;
    logic [15:0] exp_base;
    logic [15:0] exp_wdata;
    int          flit_idx;

    typedef struct {
        logic        op;
        logic [15:0] addr;
        logic [15:0] data;
        logic [35:0] exp_flit;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    root_host_input_unit #(
        .CMD_FIFO_DEPTH     (8),
        .MAX_RD_OUTSTANDING (16),
        .LEN_WIDTH          (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_req_vld  (host_req_vld),
        .host_req_rdy  (host_req_rdy),
        .host_req_op   (host_req_op),
        .host_req_addr (host_req_addr),
        .host_req_data (host_req_data),
        .host_req_len  (host_req_len),
        .router_rdy    (router_rdy),
        .tx_block      (tx_block),
        .tx_en         (tx_en),
        .tx_data       (tx_data),
        .rd_resp       (rd_resp),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    // Compare a 36-bit value.
    task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Compare a single-bit value.
    task automatic checkBit(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Compare an integer count.
    task automatic checkInt(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change at the falling edge, well away from the active edge.
    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Present one command on the host port.
    task automatic applyStimulus(input logic op, input logic [7:0] len,
                                 input logic [15:0] addr, input logic [15:0] data);
        host_req_vld  = 1'b1;
        host_req_op   = op;
        host_req_len  = len;
        host_req_addr = addr;
        host_req_data = data;
    endtask

    // Set the expected flit stream for the next burst.
    task automatic setStream(input logic [3:0] info, input logic [15:0] base, input logic [15:0] wdata);
        exp_info  = info;
        exp_base  = base;
        exp_wdata = wdata;
        flit_idx  = 0;
    endtask

    // Let the outputs settle, then check any flit against the expected stream.
    task automatic observe();
        logic [15:0] exp_addr;
        logic [15:0] exp_payload;
        #1;
        if (tx_en === 1'b1) begin
            exp_addr    = exp_base + 16'(flit_idx);
            exp_payload = (exp_info == 4'h2) ? 16'h0000 : exp_wdata;
            checkOutput($sformatf("flit%0d", flit_idx), tx_data, {exp_info, exp_addr, exp_payload});
            flit_idx++;
        end
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 16'h0010, 16'hBEEF, 36'h1_0010_BEEF, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h1234, 36'h1_FFFF_1234, 1'b0};
        vecs[2] = '{1'b1, 16'h0ABC, 16'h5555, 36'h2_0ABC_0000, 1'b1};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 36'h1_0000_0000, 1'b0};
        vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 36'h2_FFFF_0000, 1'b1};

        rst           = 1'b1;
        host_req_vld  = 1'b0;
        host_req_op   = 1'b0;
        host_req_addr = 16'h0;
        host_req_data = 16'h0;
        host_req_len  = 8'h0;
        router_rdy    = 1'b1;
        tx_block      = 1'b0;
        rd_resp       = 1'b0;
        setStream(4'h1, 16'h0, 16'h0);

        // Reset state.
        nextCycle();
        nextCycle();
        #1;
        checkBit("rst_tx_en", tx_en, 1'b0);
        checkOutput("rst_tx_data", tx_data, 36'h0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkBit("rst_rdy", host_req_rdy, 1'b1);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_err", err_underflow, 1'b0);

        // Single-beat commands: two-cycle latency, flit encoding, busy afterwards.
        for (int v = 0; v < 5; v++) begin
            nextCycle();
            applyStimulus(vecs[v].op, 8'd0, vecs[v].addr, vecs[v].data);
            #1;
            checkBit($sformatf("v%0d_rdy", v), host_req_rdy, 1'b1);
            checkBit($sformatf("v%0d_tx_c0", v), tx_en, 1'b0);
            nextCycle();
            host_req_vld = 1'b0;
            #1;
            checkBit($sformatf("v%0d_tx_c1", v), tx_en, 1'b0);
            nextCycle();
            #1;
            checkBit($sformatf("v%0d_tx_c2", v), tx_en, 1'b1);
            checkOutput($sformatf("v%0d_flit", v), tx_data, vecs[v].exp_flit);
            nextCycle();
            #1;
            checkBit($sformatf("v%0d_tx_c3", v), tx_en, 1'b0);
            checkBit($sformatf("v%0d_busy_c3", v), busy, vecs[v].exp_busy);
            if (vecs[v].op) begin
                nextCycle();
                rd_resp = 1'b1;
                #1;
                nextCycle();
                rd_resp = 1'b0;
                #1;
                checkBit($sformatf("v%0d_busy_drained", v), busy, 1'b0);
            end
        end

        // Read burst wrapping through 0xFFFF.
        setStream(4'h2, 16'hFFFE, 16'h0);
        nextCycle();
        applyStimulus(1'b1, 8'd3, 16'hFFFE, 16'h7777);
        observe();
        nextCycle();
        host_req_vld = 1'b0;
        observe();
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            observe();
        end
        checkInt("wrap_burst_count", flit_idx, 4);
        checkBit("wrap_busy_outstanding", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            rd_resp = 1'b1;
            #1;
            if (i == 3) checkBit("wrap_busy_last_resp", busy, 1'b1);
        end
        nextCycle();
        rd_resp = 1'b0;
        #1;
        checkBit("wrap_busy_drained", busy, 1'b0);
        checkBit("wrap_err", err_underflow, 1'b0);

        // Long read burst throttled at the outstanding limit.
        setStream(4'h2, 16'h0200, 16'h0);
        nextCycle();
        applyStimulus(1'b1, 8'd19, 16'h0200, 16'h0);
        observe();
        nextCycle();
        host_req_vld = 1'b0;
        observe();
        for (int i = 0; i < 30; i++) begin
            nextCycle();
            observe();
        end
        checkInt("rd_limit_count", flit_idx, 16);
        nextCycle();
        rd_resp = 1'b1;
        observe();
        nextCycle();
        rd_resp = 1'b0;
        observe();
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            observe();
        end
        checkInt("rd_one_more", flit_idx, 17);
        nextCycle();
        rd_resp = 1'b1;
        observe();
        nextCycle();
        rd_resp = 1'b1;
        observe();
        checkBit("resp_with_tx", tx_en, 1'b1);
        nextCycle();
        rd_resp = 1'b0;
        observe();
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            observe();
        end
        checkInt("rd_resp_and_tx_count", flit_idx, 19);
        nextCycle();
        rd_resp = 1'b1;
        observe();
        nextCycle();
        rd_resp = 1'b0;
        observe();
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            observe();
        end
        checkInt("rd_total_count", flit_idx, 20);
        for (int i = 0; i < 16; i++) begin
            nextCycle();
            rd_resp = 1'b1;
            #1;
        end
        nextCycle();
        rd_resp = 1'b0;
        #1;
        checkBit("limit_busy_drained", busy, 1'b0);
        checkBit("limit_err", err_underflow, 1'b0);

        // Flow control mid-burst: router_rdy low then tx_block high.
        setStream(4'h1, 16'h0100, 16'h1234);
        nextCycle();
        applyStimulus(1'b0, 8'd5, 16'h0100, 16'h1234);
        observe();
        nextCycle();
        host_req_vld = 1'b0;
        observe();
        nextCycle();
        observe();
        nextCycle();
        observe();
        checkInt("fc_pre_stall", flit_idx, 2);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            router_rdy = 1'b0;
            observe();
            checkBit($sformatf("fc_no_credit%0d", i), tx_en, 1'b0);
        end
        nextCycle();
        router_rdy = 1'b1;
        tx_block   = 1'b1;
        observe();
        checkBit("fc_blocked", tx_en, 1'b0);
        nextCycle();
        tx_block = 1'b0;
        observe();
        checkBit("fc_resume", tx_en, 1'b1);
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            observe();
        end
        checkInt("fc_total", flit_idx, 6);
        checkBit("fc_busy", busy, 1'b0);

        // Fill the command FIFO while no credit is available.
        router_rdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            nextCycle();
            applyStimulus(1'b0, 8'd0, 16'(i), 16'h00AA);
            #1;
            checkBit($sformatf("fill_rdy%0d", i), host_req_rdy, 1'b1);
        end
        nextCycle();
        host_req_vld = 1'b0;
        #1;
        checkBit("full_rdy", host_req_rdy, 1'b0);
        checkBit("full_busy", busy, 1'b1);
        nextCycle();
        rst = 1'b1;
        #1;
        nextCycle();
        rst        = 1'b0;
        router_rdy = 1'b1;
        #1;
        checkBit("flush_rdy", host_req_rdy, 1'b1);
        checkBit("flush_busy", busy, 1'b0);

        // Reset during beat 1 of a write burst, then an unexpected read response.
        setStream(4'h1, 16'h0300, 16'hCAFE);
        nextCycle();
        applyStimulus(1'b0, 8'd5, 16'h0300, 16'hCAFE);
        observe();
        nextCycle();
        host_req_vld = 1'b0;
        observe();
        nextCycle();
        observe();
        checkInt("mid_rst_first_flit", flit_idx, 1);
        nextCycle();
        rst = 1'b1;
        #1;
        checkBit("mid_rst_tx_en", tx_en, 1'b0);
        checkOutput("mid_rst_tx_data", tx_data, 36'h0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkBit("post_rst_tx_en", tx_en, 1'b0);
        checkBit("post_rst_busy", busy, 1'b0);
        checkBit("post_rst_rdy", host_req_rdy, 1'b1);
        nextCycle();
        #1;
        checkBit("post_rst_quiet", tx_en, 1'b0);
        checkBit("pre_underflow_err", err_underflow, 1'b0);
        nextCycle();
        rd_resp = 1'b1;
        #1;
        nextCycle();
        rd_resp = 1'b0;
        #1;
        checkBit("underflow_err", err_underflow, 1'b1);
        checkBit("underflow_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
